// File: rtl/exe_stage_md.sv
// exe_stage_md: pipeline execute stage with registered EX/MEM bank and iterative mult/div (HI/LO).
// Define EXE_OVERFLOW_TRAP_EN to add ex_ovf and suppress GPR writes on signed add/sub overflow.
module exe_stage_md #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   pc,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] reg_data1,
    input  logic [DATA_W-1:0] reg_data2,
    input  logic [DATA_W-1:0] ext_immed,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic [1:0]        alu_op,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic              reg_write_in,
    input  logic              flush,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_reg_desti,
    output logic [PC_W-1:0]   ex_target,
    output logic [DATA_W-1:0] ex_alu_result,
    output logic              ex_zero,
    output logic [DATA_W-1:0] ex_reg_data2,
    output logic              ex_reg_write
`ifdef EXE_OVERFLOW_TRAP_EN
    ,
    output logic              ex_ovf
`endif
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [DATA_W-1:0]   r_hi, r_lo, r_wh, r_wl, r_b;
    logic                r_is_div, r_neg_q, r_neg_r, r_dz;

    logic [DATA_W-1:0]   w_b, w_sum, w_dif, w_res, w_ma, w_mb;
    logic [REG_AW-1:0]   w_dest;
    logic [PC_W-1:0]     w_target;
    logic                w_accept, w_is_md, w_sa, w_sb, w_ok;
    logic [DATA_W:0]     w_madd, w_sh, w_diff;
    logic [DATA_W-1:0]   w_nh, w_nl, w_quo, w_rem, w_fh, w_fl;
    logic [2*DATA_W-1:0] w_prod;

    assign w_b       = alu_src ? ext_immed : reg_data2;
    assign w_dest    = reg_dst ? rd : rt;
    assign w_sum     = reg_data1 + w_b;
    assign w_dif     = reg_data1 - w_b;
    assign w_target  = pc + PC_W'($signed({ext_immed, 2'b00}));
    assign w_accept  = in_valid && r_state == IDLE;
    assign w_is_md   = alu_op == 2'b10 && funct[5:2] == 4'b0110;
    assign stall_out = r_state == BUSY;

    always_comb begin
        w_res = '0;
        case (alu_op)
            2'b00: w_res = w_sum;
            2'b01: w_res = w_dif;
            2'b11: w_res = reg_data1 | w_b;
            default:
                case (funct)
                    6'h20, 6'h21: w_res = w_sum;
                    6'h22, 6'h23: w_res = w_dif;
                    6'h24:        w_res = reg_data1 & w_b;
                    6'h25:        w_res = reg_data1 | w_b;
                    6'h26:        w_res = reg_data1 ^ w_b;
                    6'h27:        w_res = ~(reg_data1 | w_b);
                    6'h2A:        w_res = {{(DATA_W-1){1'b0}}, $signed(reg_data1) < $signed(w_b)};
                    6'h2B:        w_res = {{(DATA_W-1){1'b0}}, reg_data1 < w_b};
                    6'h10:        w_res = r_hi;
                    6'h12:        w_res = r_lo;
                    default:      w_res = '0;
                endcase
        endcase
    end

`ifdef EXE_OVERFLOW_TRAP_EN
    logic w_ovf;
    assign w_ovf = ((alu_op == 2'b00 || (alu_op == 2'b10 && funct == 6'h20)) &&
                    reg_data1[DATA_W-1] == w_b[DATA_W-1] && w_sum[DATA_W-1] != reg_data1[DATA_W-1]) ||
                   ((alu_op == 2'b01 || (alu_op == 2'b10 && funct == 6'h22)) &&
                    reg_data1[DATA_W-1] != w_b[DATA_W-1] && w_dif[DATA_W-1] != reg_data1[DATA_W-1]);
`else
    logic w_ovf;
    assign w_ovf = 1'b0;
`endif

    // Iterate on magnitudes; signs are reapplied when the last step retires into HI/LO.
    assign w_sa   = ~funct[0] & reg_data1[DATA_W-1];
    assign w_sb   = ~funct[0] & reg_data2[DATA_W-1];
    assign w_ma   = w_sa ? -reg_data1 : reg_data1;
    assign w_mb   = w_sb ? -reg_data2 : reg_data2;
    assign w_madd = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : '0);
    assign w_sh   = {r_wh, r_wl[DATA_W-1]};
    assign w_diff = w_sh - {1'b0, r_b};
    assign w_ok   = ~w_diff[DATA_W];
    assign w_nh   = r_is_div ? (w_ok ? w_diff[DATA_W-1:0] : w_sh[DATA_W-1:0]) : w_madd[DATA_W:1];
    assign w_nl   = r_is_div ? {r_wl[DATA_W-2:0], w_ok} : {w_madd[0], r_wl[DATA_W-1:1]};
    assign w_prod = r_neg_q ? -{w_nh, w_nl} : {w_nh, w_nl};
    assign w_quo  = r_dz ? '1 : (r_neg_q ? -w_nl : w_nl);
    assign w_rem  = r_neg_r ? -w_nh : w_nh;
    assign w_fh   = r_is_div ? w_rem : w_prod[2*DATA_W-1:DATA_W];
    assign w_fl   = r_is_div ? w_quo : w_prod[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_wh          <= '0;
            r_wl          <= '0;
            r_b           <= '0;
            r_is_div      <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            ex_valid      <= 1'b0;
            ex_reg_desti  <= '0;
            ex_target     <= '0;
            ex_alu_result <= '0;
            ex_zero       <= 1'b0;
            ex_reg_data2  <= '0;
            ex_reg_write  <= 1'b0;
`ifdef EXE_OVERFLOW_TRAP_EN
            ex_ovf        <= 1'b0;
`endif
        end else begin
            ex_valid     <= w_accept & ~flush;
            ex_reg_write <= reg_write_in & w_accept & ~flush & ~w_is_md & ~w_ovf;
`ifdef EXE_OVERFLOW_TRAP_EN
            ex_ovf       <= w_ovf & w_accept & ~flush;
`endif
            if (w_accept) begin
                ex_reg_desti  <= w_dest;
                ex_target     <= w_target;
                ex_alu_result <= w_res;
                ex_zero       <= w_res == '0;
                ex_reg_data2  <= reg_data2;
            end
            if (r_state == IDLE) begin
                if (w_accept && w_is_md) begin
                    r_state  <= BUSY;
                    r_cnt    <= CW'(DATA_W - 1);
                    r_is_div <= funct[1];
                    r_wh     <= '0;
                    r_wl     <= funct[1] ? w_ma : w_mb;
                    r_b      <= funct[1] ? w_mb : w_ma;
                    r_neg_q  <= w_sa ^ w_sb;
                    r_neg_r  <= w_sa;
                    r_dz     <= funct[1] && reg_data2 == '0;
                end
            end else begin
                r_wh  <= w_nh;
                r_wl  <= w_nl;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_state <= IDLE;
                    r_hi    <= w_fh;
                    r_lo    <= w_fl;
                end
            end
        end
    end
endmodule
